// File: rtl/dcache_axi_rd_bridge.sv
// rtl/dcache_axi_rd_bridge.sv - single-outstanding AXI read bridge for the dcache miss port
module dcache_axi_rd_bridge #(
  parameter logic [3:0]  RD_ID = 4'd1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      s_araddr,
  input  logic             s_arvalid,
  output logic             s_arready,
  output logic [31:0]      s_rdata,
  output logic             s_rvalid,
  input  logic             s_rready,
  output logic [3:0]       arid,
  output logic [31:0]      araddr,
  output logic [7:0]       arlen,
  output logic [2:0]       arsize,
  output logic [1:0]       arburst,
  output logic [1:0]       arlock,
  output logic [3:0]       arcache,
  output logic [2:0]       arprot,
  output logic             arvalid,
  input  logic             arready,
  input  logic [3:0]       rid,
  input  logic [31:0]      rdata,
  input  logic [1:0]       rresp,
  input  logic             rlast,
  input  logic             rvalid,
  output logic             rready,
  output logic             bus_err,
  output logic [31:0]      err_addr,
  output logic [CNT_W-1:0] stray_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_addr_q;
  logic [31:0]      r_data_q;
  logic [1:0]       r_resp_q;
  logic [31:0]      r_err_addr;
  logic             r_first_resp;
  logic             r_bus_err;
  logic [CNT_W-1:0] r_stray_cnt;
  logic             w_match;
  logic             w_stray;
  logic             w_unused;

  assign w_match  = rvalid && (rid == RD_ID);
  assign w_stray  = rvalid && (rid != RD_ID);
  assign w_unused = r_resp_q[0];

  assign arid      = RD_ID;
  assign araddr    = {r_addr_q[31:2], 2'b00};
  assign arlen     = 8'd0;
  assign arsize    = 3'd2;
  assign arburst   = 2'b01;
  assign arlock    = 2'b00;
  assign arcache   = 4'd0;
  assign arprot    = 3'd0;
  assign s_rdata   = r_data_q;
  assign bus_err   = r_bus_err;
  assign err_addr  = r_err_addr;
  assign stray_cnt = r_stray_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Foreign-ID beats are drained in every state so they never stall the interconnect.
  always_comb begin
    w_next    = r_state;
    s_arready = 1'b0;
    arvalid   = 1'b0;
    s_rvalid  = 1'b0;
    rready    = (rid != RD_ID);
    case (r_state)
      S_IDLE: begin
        s_arready = 1'b1;
        if (s_arvalid) w_next = S_ADDR;
      end
      S_ADDR: begin
        arvalid = 1'b1;
        if (arready) w_next = S_DATA;
      end
      S_DATA: begin
        rready = 1'b1;
        if (w_match && rlast) w_next = S_RESP;
      end
      S_RESP: begin
        s_rvalid = 1'b1;
        if (s_rready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_addr_q     <= 32'd0;
      r_data_q     <= 32'd0;
      r_resp_q     <= 2'b00;
      r_err_addr   <= 32'd0;
      r_first_resp <= 1'b0;
      r_bus_err    <= 1'b0;
      r_stray_cnt  <= '0;
    end else begin
      if (r_state == S_IDLE && s_arvalid) r_addr_q <= s_araddr;
      if (r_state == S_DATA && w_match) begin
        r_data_q <= rdata;
        r_resp_q <= rresp;
      end
      // Error is reported from the registered response, one cycle into RESP.
      r_first_resp <= (r_state == S_DATA) && w_match && rlast;
      r_bus_err    <= r_first_resp && r_resp_q[1];
      if (r_first_resp && r_resp_q[1]) r_err_addr <= r_addr_q;
      if (w_stray && (r_stray_cnt != {CNT_W{1'b1}})) r_stray_cnt <= r_stray_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dcache_axi_rd_bridge.sv
// tb/tb_dcache_axi_rd_bridge.sv - self-checking bench for dcache_axi_rd_bridge
module tb_dcache_axi_rd_bridge;
  localparam logic [3:0] RD_ID = 4'd1;
  localparam int CNT_W = 8;
  localparam int SAT = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic resetn;
  logic [31:0] s_araddr;
  logic s_arvalid;
  logic s_arready;
  logic [31:0] s_rdata;
  logic s_rvalid;
  logic s_rready;
  logic [3:0] arid;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic [1:0] arlock;
  logic [3:0] arcache;
  logic [2:0] arprot;
  logic arvalid;
  logic arready;
  logic [3:0] rid;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic rvalid;
  logic rready;
  logic bus_err;
  logic [31:0] err_addr;
  logic [CNT_W-1:0] stray_cnt;

  dcache_axi_rd_bridge #(.RD_ID(RD_ID), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .bus_err(bus_err), .err_addr(err_addr), .stray_cnt(stray_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int bus_err_cnt = 0;
  int ar_hs_cnt = 0;
  int exp_stray = 0;
  logic [31:0] exp_err_addr = 32'd0;

  always @(negedge clk) begin
    if (bus_err === 1'b1) bus_err_cnt++;
    if (arvalid === 1'b1 && arready === 1'b1) ar_hs_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] addr;
    int          ar_dly;
    int          n_stray;
    int          n_part;
    logic [31:0] data;
    logic [1:0]  resp;
    int          s_dly;
    logic [31:0] stray_data;
    logic [31:0] exp_araddr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic run_txn(input logic [31:0] addr, input int ar_dly, input int n_stray,
                         input int n_part, input logic [31:0] data, input logic [1:0] resp,
                         input int s_dly, input logic [31:0] stray_data,
                         input logic [31:0] exp_araddr, input logic [31:0] exp_rdata,
                         input logic exp_err);
    int ar0, be0, ns, np, tmp;
    logic ok;
    logic [31:0] first_rdata;
    ar0 = ar_hs_cnt;
    be0 = bus_err_cnt;
    s_araddr = addr;
    s_arvalid = 1'b1;
    @(negedge clk);
    chk("req_s_arready", s_arready, 1);
    tick;
    s_arvalid = 1'b0;
    s_araddr = $urandom;
    ok = 1'b1;
    for (int i = 0; i <= ar_dly; i++) begin
      arready = (i == ar_dly);
      @(negedge clk);
      if (arvalid !== 1'b1 || araddr !== exp_araddr || s_arready !== 1'b0 || s_rvalid !== 1'b0) ok = 1'b0;
      tick;
    end
    arready = 1'b0;
    chk("ar_hold", ok, 1);
    chk("araddr", araddr, exp_araddr);
    chk("ar_attr", {6'd0, arid, arlen, arsize, arburst, arlock, arcache, arprot},
        {6'd0, RD_ID, 8'd0, 3'd2, 2'b01, 2'b00, 4'd0, 3'd0});
    ns = n_stray;
    np = n_part;
    ok = 1'b1;
    while (ns + np > 0) begin
      if ($urandom_range(0, 3) == 0) begin
        rvalid = 1'b0;
      end else if (ns > 0 && (np == 0 || $urandom_range(0, 1) == 1)) begin
        tmp = $urandom_range(2, 16);
        rvalid = 1'b1; rid = tmp[3:0]; rdata = stray_data;
        rresp = 2'($urandom); rlast = 1'($urandom);
        ns--;
        exp_stray = sat_inc(exp_stray);
      end else begin
        rvalid = 1'b1; rid = RD_ID; rdata = $urandom; rresp = 2'($urandom); rlast = 1'b0;
        np--;
      end
      @(negedge clk);
      if (rready !== 1'b1 || s_rvalid !== 1'b0 || s_arready !== 1'b0 || arvalid !== 1'b0) ok = 1'b0;
      tick;
    end
    rvalid = 1'b1; rid = RD_ID; rdata = data; rresp = resp; rlast = 1'b1;
    @(negedge clk);
    if (rready !== 1'b1) ok = 1'b0;
    tick;
    rvalid = 1'b0; rlast = 1'b0;
    chk("data_rready", ok, 1);
    ok = 1'b1;
    first_rdata = 32'hx;
    for (int k = 0; k <= s_dly; k++) begin
      s_rready = (k == s_dly);
      @(negedge clk);
      if (k == 0) first_rdata = s_rdata;
      if (s_rvalid !== 1'b1 || s_rdata !== exp_rdata || s_arready !== 1'b0 || arvalid !== 1'b0) ok = 1'b0;
      tick;
    end
    s_rready = 1'b0;
    chk("s_rdata", first_rdata, exp_rdata);
    chk("resp_hold", ok, 1);
    @(negedge clk);
    chk("turnaround", {s_arready, s_rvalid}, 2'b10);
    tick;
    tick;
    chk("ar_count", ar_hs_cnt - ar0, 1);
    chk("bus_err_pulses", bus_err_cnt - be0, {31'd0, exp_err});
    if (exp_err) exp_err_addr = addr;
    chk("err_addr", err_addr, exp_err_addr);
    chk("stray_cnt", {24'd0, stray_cnt}, exp_stray);
  endtask

  vec_t vecs[8];

  initial begin
    logic [31:0] addr, data;
    logic [1:0] resp;
    logic [3:0] tid;
    int tmp;

    vecs[0] = '{32'h0000_1004, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 0, 32'h0,         32'h0000_1004, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{32'h0000_2008, 5, 0, 0, 32'hCAFE_F00D, 2'b00, 3, 32'h0,         32'h0000_2008, 32'hCAFE_F00D, 1'b0};
    vecs[2] = '{32'h0000_3000, 0, 1, 0, 32'h2222_2222, 2'b00, 0, 32'h1111_1111, 32'h0000_3000, 32'h2222_2222, 1'b0};
    vecs[3] = '{32'hBFC0_0008, 1, 0, 0, 32'h0000_0000, 2'b10, 1, 32'h0,         32'hBFC0_0008, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h0000_4007, 0, 0, 0, 32'h1234_5678, 2'b00, 0, 32'h0,         32'h0000_4004, 32'h1234_5678, 1'b0};
    vecs[5] = '{32'h0000_5010, 2, 0, 2, 32'h5A5A_5A5A, 2'b00, 2, 32'h0,         32'h0000_5010, 32'h5A5A_5A5A, 1'b0};
    vecs[6] = '{32'h8000_0013, 0, 2, 1, 32'hFFFF_0000, 2'b11, 0, 32'hAAAA_AAAA, 32'h8000_0010, 32'hFFFF_0000, 1'b1};
    vecs[7] = '{32'h0000_6000, 0, 0, 0, 32'h0BAD_CAFE, 2'b01, 0, 32'h0,         32'h0000_6000, 32'h0BAD_CAFE, 1'b0};

    resetn = 1'b0;
    s_araddr = 32'd0; s_arvalid = 1'b0; s_rready = 1'b0; arready = 1'b0;
    rid = RD_ID; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    repeat (3) tick;
    @(negedge clk);
    chk("rst_s_arready", s_arready, 1);
    chk("rst_valids", {arvalid, s_rvalid, bus_err, rready}, 4'b0000);
    chk("rst_err_addr", err_addr, 32'd0);
    chk("rst_stray_cnt", {24'd0, stray_cnt}, 32'd0);
    chk("rst_s_rdata", s_rdata, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    tick;
    resetn = 1'b1;
    tick;

    for (int v = 0; v < 8; v++) begin
      run_txn(vecs[v].addr, vecs[v].ar_dly, vecs[v].n_stray, vecs[v].n_part, vecs[v].data,
              vecs[v].resp, vecs[v].s_dly, vecs[v].stray_data, vecs[v].exp_araddr,
              vecs[v].exp_rdata, vecs[v].exp_err);
    end

    for (int t = 0; t < 40; t++) begin
      addr = $urandom;
      data = $urandom;
      resp = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        tmp = $urandom_range(0, 15);
        tid = tmp[3:0];
        rid = tid; rvalid = 1'b1; rdata = $urandom; rlast = 1'($urandom);
        @(negedge clk);
        chk("idle_rready", rready, {31'd0, tid != RD_ID});
        tick;
        rvalid = 1'b0; rid = RD_ID;
        if (tid != RD_ID) exp_stray = sat_inc(exp_stray);
      end
      run_txn(addr, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2), data, resp,
              $urandom_range(0, 3), $urandom, {addr[31:2], 2'b00}, data, resp[1]);
    end

    for (int n = 0; n < 300; n++) begin
      tmp = $urandom_range(2, 16);
      rid = tmp[3:0]; rvalid = 1'b1; rdata = $urandom;
      tick;
      exp_stray = sat_inc(exp_stray);
    end
    rvalid = 1'b0; rid = RD_ID;
    @(negedge clk);
    chk("stray_saturated", {24'd0, stray_cnt}, SAT);
    tick;
    run_txn(32'h0000_7000, 0, 3, 0, 32'h7777_7777, 2'b00, 0, 32'h3333_3333,
            32'h0000_7000, 32'h7777_7777, 1'b0);

    s_araddr = 32'h0000_9000; s_arvalid = 1'b1;
    tick;
    s_arvalid = 1'b0; arready = 1'b1;
    tick;
    arready = 1'b0;
    tick;
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    rid = RD_ID; rvalid = 1'b0;
    exp_stray = 0;
    exp_err_addr = 32'd0;
    @(negedge clk);
    chk("rstdata_s_arready", s_arready, 1);
    chk("rstdata_rready", rready, 0);
    chk("rstdata_s_rvalid", s_rvalid, 0);
    chk("rstdata_s_rdata", s_rdata, 32'd0);
    chk("rstdata_err_addr", err_addr, 32'd0);
    tick;
    run_txn(32'h0000_A004, 1, 0, 0, 32'h600D_600D, 2'b00, 1, 32'h0,
            32'h0000_A004, 32'h600D_600D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
